regfile_wb_arbiter: RTL and testbench

Write-port arbiter for the 32x32 register file. It shares the file's single write port (enable, rd, data, committed on the file's negedge) between two writeback requesters: the ALU and the memory/load unit. Memory requests win the port, and losing ALU requests are held in a small in-order queue. It guarantees that writes to the same destination register commit in program order, and it sits between the execute/memory stages and the register file.

---
 rtl/regfile_wb_arbiter.sv | 147 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Arbitrates the register file's single write port between the load unit
//   and the ALU. A load always wins the port. An ALU request that loses is
//   held in an in-order queue. A load is stalled while an older queued ALU
//   write targets the same register, so same-register writes commit in
//   program order. Requests to x0 are accepted and then dropped.
//
// Optional feature (macro REGFILE_WB_FWD_EN):
//   Adds forwarding lookups over the queue and the wb stage.
//
// Ports:
//   clk, reset           clock; synchronous active-low reset
//   alu_valid/rd/data    ALU writeback request; alu_ready handshake
//   mem_valid/rd/data    load writeback request; mem_ready handshake
//   wb_en/wb_rd/wb_data  registered write port into the register file
//   q_count              number of queued ALU entries
//   fwd_rs1/2, fwd1/2_*  forwarding lookup (REGFILE_WB_FWD_EN only)
module regfile_wb_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       alu_valid,
    input  logic [4:0]                 alu_rd,
    input  logic [31:0]                alu_data,
    output logic                       alu_ready,
    input  logic                       mem_valid,
    input  logic [4:0]                 mem_rd,
    input  logic [31:0]                mem_data,
    output logic                       mem_ready,
    output logic                       wb_en,
    output logic [4:0]                 wb_rd,
    output logic [31:0]                wb_data,
    output logic [$clog2(DEPTH+1)-1:0] q_count
`ifdef REGFILE_WB_FWD_EN
    ,
    input  logic [4:0]                 fwd_rs1,
    input  logic [4:0]                 fwd_rs2,
    output logic                       fwd1_hit,
    output logic [31:0]                fwd1_data,
    output logic                       fwd2_hit,
    output logic [31:0]                fwd2_data
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [4:0]    q_rd   [DEPTH];
    logic [31:0]   q_data [DEPTH];
    logic [DEPTH-1:0] q_vld;
    logic [PW-1:0] rptr, wptr;

    logic mem_conflict, mem_fire, alu_fire;
    logic mem_issue, q_issue, alu_direct, push, pop;

    // A load must not overtake an older queued ALU write to the same register.
    always_comb begin
        mem_conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_vld[i] && q_rd[i] == mem_rd)
                mem_conflict = 1'b1;
        end
        mem_conflict = mem_conflict & mem_valid & (mem_rd != 5'd0);
    end

    assign mem_ready = reset & ~mem_conflict;
    assign alu_ready = reset & (q_count < CW'(DEPTH));
    assign mem_fire  = mem_valid & mem_ready;
    assign alu_fire  = alu_valid & alu_ready;

    // Exactly one winner: load, then queue head, then a direct ALU write.
    // The ALU goes direct only when nothing older is queued.
    assign mem_issue  = mem_fire & (mem_rd != 5'd0);
    assign q_issue    = ~mem_issue & (q_count != '0);
    assign alu_direct = ~mem_issue & (q_count == '0) & alu_fire & (alu_rd != 5'd0);
    assign pop        = q_issue;
    assign push       = alu_fire & (alu_rd != 5'd0) & ~alu_direct;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wb_en   <= 1'b0;
            wb_rd   <= 5'd0;
            wb_data <= 32'd0;
            q_count <= '0;
            rptr    <= '0;
            wptr    <= '0;
            q_vld   <= '0;
        end else begin
            wb_en <= mem_issue | q_issue | alu_direct;
            if (mem_issue) begin
                wb_rd   <= mem_rd;
                wb_data <= mem_data;
            end else if (q_issue) begin
                wb_rd   <= q_rd[rptr];
                wb_data <= q_data[rptr];
            end else if (alu_direct) begin
                wb_rd   <= alu_rd;
                wb_data <= alu_data;
            end

            // Push and pop never hit the same slot: pop needs a non-empty
            // queue, push needs a non-full one, so rptr==wptr excludes both.
            if (pop) begin
                q_vld[rptr] <= 1'b0;
                rptr        <= rptr + PW'(1);
            end
            if (push) begin
                q_vld[wptr]  <= 1'b1;
                q_rd[wptr]   <= alu_rd;
                q_data[wptr] <= alu_data;
                wptr         <= wptr + PW'(1);
            end

            if (push && !pop)
                q_count <= q_count + CW'(1);
            else if (pop && !push)
                q_count <= q_count - CW'(1);
        end
    end

`ifdef REGFILE_WB_FWD_EN
    // Youngest match wins: walk from the wb stage through the queue oldest
    // to youngest so later hits overwrite earlier ones.
    function automatic logic [32:0] fwd_lookup(input logic [4:0] rs);
        logic [32:0]   r;
        logic [PW-1:0] idx;
        r = 33'd0;
        if (rs != 5'd0) begin
            if (wb_en && wb_rd == rs)
                r = {1'b1, wb_data};
            for (int i = 0; i < DEPTH; i++) begin
                idx = rptr + PW'(i);
                if (q_vld[idx] && q_rd[idx] == rs)
                    r = {1'b1, q_data[idx]};
            end
        end
        return r;
    endfunction

    always_comb begin
        {fwd1_hit, fwd1_data} = fwd_lookup(fwd_rs1);
        {fwd2_hit, fwd2_data} = fwd_lookup(fwd_rs2);
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, mem_valid;
    logic [4:0]  alu_rd, mem_rd;
    logic [31:0] alu_data, mem_data;
    logic        alu_ready, mem_ready;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [1:0]  q_count;
`ifdef REGFILE_WB_FWD_EN
    logic [4:0]  fwd_rs1 = '0, fwd_rs2 = '0;
    logic        fwd1_hit, fwd2_hit;
    logic [31:0] fwd1_data, fwd2_data;
`endif

    regfile_wb_arbiter #(.DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .q_count(q_count)
`ifdef REGFILE_WB_FWD_EN
        , .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
        .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
        .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data)
`endif
    );

    always #5 clk = ~clk;

    int    n_total = 0;
    int    n_pass  = 0;
    wb_t   exp_q[$];
    logic [31:0] regs [32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [4:0] rd, input logic [31:0] data);
        wb_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every committed write (register file writes on negedge)
    // is matched against the next expected write in commit order.
    always @(negedge clk) begin
        if (wb_en === 1'b1) begin
            regs[wb_rd] = wb_data;
            if (exp_q.size() == 0) begin
                chk("unexpected_write_rd", {27'd0, wb_rd}, 32'hffff_ffff);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                chk("sb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                chk("sb_data", wb_data, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        reset = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
        mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'h22;

        // Reset held with both requesters valid
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
            chk("rst_q_count", {30'd0, q_count}, 32'd0);
            chk("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
            chk("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
        end
        chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        reset = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0;
        tick();
        chk("post_rst_wb_en", {31'd0, wb_en}, 32'd0);

        // Lone ALU write
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
        #1 chk("lone_alu_ready", {31'd0, alu_ready}, 32'd1);
        push_exp(5'd5, 32'h1234);
        tick();
        alu_valid = 1'b0;
        chk("lone_wb_en", {31'd0, wb_en}, 32'd1);
        chk("lone_wb_rd", {27'd0, wb_rd}, 32'd5);
        chk("lone_wb_data", wb_data, 32'h1234);
        chk("lone_q_count", {30'd0, q_count}, 32'd0);
        tick();
        chk("idle_wb_en", {31'd0, wb_en}, 32'd0);
        chk("idle_wb_rd_hold", {27'd0, wb_rd}, 32'd5);
        chk("idle_wb_data_hold", wb_data, 32'h1234);

        // Collision: load wins, ALU queued for one cycle
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA;
        mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'hB;
        push_exp(5'd4, 32'hB); push_exp(5'd3, 32'hA);
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0;
        chk("coll1_wb_rd", {27'd0, wb_rd}, 32'd4);
        chk("coll1_q_count", {30'd0, q_count}, 32'd1);
        tick();
        chk("coll2_wb_en", {31'd0, wb_en}, 32'd1);
        chk("coll2_wb_rd", {27'd0, wb_rd}, 32'd3);
        chk("coll2_q_count", {30'd0, q_count}, 32'd0);
        tick();

        // Full queue: load stream holds the port while ALU fills the queue
        for (int c = 0; c < 4; c++) begin
            mem_valid = 1'b1; mem_rd = 5'(10 + c); mem_data = 32'(32'h100 + 10 + c);
            alu_valid = 1'b1;
            alu_rd    = (c < 2) ? 5'(20 + c) : 5'd22;
            alu_data  = 32'h200 + 32'(alu_rd);
            push_exp(mem_rd, mem_data);
            #1 chk("full_alu_ready", {31'd0, alu_ready}, (c < 2) ? 32'd1 : 32'd0);
            tick();
            chk("full_wb_en", {31'd0, wb_en}, 32'd1);
            chk("full_q_count", {30'd0, q_count}, (c == 0) ? 32'd1 : 32'd2);
        end
        mem_valid = 1'b0;
        push_exp(5'd20, 32'h214); push_exp(5'd21, 32'h215); push_exp(5'd22, 32'h216);
        #1 chk("drain0_alu_ready", {31'd0, alu_ready}, 32'd0);
        tick();
        chk("drain0_q_count", {30'd0, q_count}, 32'd1);
        chk("drain0_wb_rd", {27'd0, wb_rd}, 32'd20);
        chk("drain1_alu_ready", {31'd0, alu_ready}, 32'd1);
        tick();
        alu_valid = 1'b0;
        chk("drain1_q_count", {30'd0, q_count}, 32'd1);
        tick();
        chk("drain2_q_count", {30'd0, q_count}, 32'd0);
        chk("drain2_wb_rd", {27'd0, wb_rd}, 32'd22);
        tick();

        // Ordering: load to rd7 waits for queued ALU write to rd7
        mem_valid = 1'b1; mem_rd = 5'd8; mem_data = 32'h80;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h1;
        push_exp(5'd8, 32'h80); push_exp(5'd7, 32'h1);
        tick();
        alu_valid = 1'b0;
        mem_rd = 5'd7; mem_data = 32'h2;
        #1 chk("order_mem_stall", {31'd0, mem_ready}, 32'd0);
        tick();
        chk("order_alu_first", wb_data, 32'h1);
        chk("order_mem_ready", {31'd0, mem_ready}, 32'd1);
        push_exp(5'd7, 32'h2);
        tick();
        mem_valid = 1'b0;
        chk("order_mem_wb", wb_data, 32'h2);
        tick();
        chk("order_final_rd7", regs[7], 32'h2);

        // x0 requests are accepted and dropped
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hBEEF;
        #1 chk("rd0_alu_ready", {31'd0, alu_ready}, 32'd1);
        chk("rd0_mem_ready", {31'd0, mem_ready}, 32'd1);
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0;
        chk("rd0_wb_en", {31'd0, wb_en}, 32'd0);
        chk("rd0_q_count", {30'd0, q_count}, 32'd0);

        // Reset mid-operation discards the queued ALU entry
        mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h99;
        alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h66;
        push_exp(5'd9, 32'h99);
        tick();
        mem_valid = 1'b0; alu_valid = 1'b0;
        chk("mid_q_count", {30'd0, q_count}, 32'd1);
        reset = 1'b0;
        tick();
        chk("mid_rst_wb_en", {31'd0, wb_en}, 32'd0);
        chk("mid_rst_q_count", {30'd0, q_count}, 32'd0);
        reset = 1'b1;
        tick();
        chk("mid_after_wb_en", {31'd0, wb_en}, 32'd0);
        tick();
        chk("mid_after2_wb_en", {31'd0, wb_en}, 32'd0);
        chk("sb_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
